// File: rtl/sev_scan_driver_pkg.sv
// ============================================================================
// Module      : sev_scan_driver_pkg
// Description : Shared 7-segment display types, constants and the hex-to-
//               segment lookup used by the scan driver and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sev_scan_driver_pkg;

    // Which of the four digit slots is currently being driven
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_idx_t;

    // All segments off (active-low) and all anodes off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] SCAN_OFF  = 4'b1111;

    // Hex nibble to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sev_decoder.sv
// ============================================================================
// Module      : sev_decoder
// Description : Combinational hex nibble to active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sev_decoder
    import sev_scan_driver_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; the caller registers the result
    always_comb begin
        seg_o = hex_to_seg(nib_i);
    end

endmodule

`default_nettype wire

// File: rtl/sev_scan_driver.sv
// ============================================================================
// Module      : sev_scan_driver
// Description : Four-digit multiplexed 7-segment driver with double-buffered
//               value (commit only at frame boundaries) and optional
//               leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sev_scan_driver
    import sev_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lzb,
    output logic [6:0]  seg,
    output logic [3:0]  scan,
    output logic        frame_done
);

    localparam int                CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] presc_q,     presc_d;
    digit_idx_t       idx_q,       idx_d;
    logic [15:0]      pending_q,   pending_d;
    logic             pend_flag_q, pend_flag_d;
    logic [15:0]      shadow_q,    shadow_d;
    logic [6:0]       seg_q,       seg_d;
    logic [3:0]       scan_q,      scan_d;
    logic             fdone_q,     fdone_d;

    logic             tick;
    logic             frame_end;
    logic             commit;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;
    logic             blank;

    sev_decoder u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    // Prescaler, digit stepping and the pending/shadow double buffer
    always_comb begin
        tick      = (presc_q == CNT_MAX);
        frame_end = tick && (idx_q == DIG3);
        commit    = frame_end && pend_flag_q;

        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = tick ? digit_idx_t'(idx_q + 2'd1) : idx_q;

        // A load coinciding with a commit lands in pending after the old
        // pending value has been handed to the shadow register
        pending_d   = load ? value : pending_q;
        pend_flag_d = pend_flag_q;
        if (load) begin
            pend_flag_d = 1'b1;
        end else if (commit) begin
            pend_flag_d = 1'b0;
        end
        shadow_d = commit ? pending_q : shadow_q;
        fdone_d  = frame_end;
    end

    // Digit selection and leading-zero blanking for the current slot
    always_comb begin
        cur_nib = shadow_q[3:0];
        blank   = 1'b0;
        case (idx_q)
            DIG1: begin
                cur_nib = shadow_q[7:4];
                blank   = (shadow_q[15:4] == 12'h000);
            end
            DIG2: begin
                cur_nib = shadow_q[11:8];
                blank   = (shadow_q[15:8] == 8'h00);
            end
            DIG3: begin
                cur_nib = shadow_q[15:12];
                blank   = (shadow_q[15:12] == 4'h0);
            end
            default: begin
                cur_nib = shadow_q[3:0];
                blank   = 1'b0;
            end
        endcase
        blank  = blank && lzb;
        scan_d = blank ? SCAN_OFF  : ~(4'b0001 << idx_q);
        seg_d  = blank ? SEG_BLANK : dec_seg;
    end

    // State and output registers; clr wins over every other input
    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q     <= '0;
            idx_q       <= DIG0;
            pending_q   <= 16'h0000;
            pend_flag_q <= 1'b0;
            shadow_q    <= 16'h0000;
            seg_q       <= SEG_BLANK;
            scan_q      <= SCAN_OFF;
            fdone_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            scan_q      <= scan_d;
            fdone_q     <= fdone_d;
        end
    end

    assign seg        = seg_q;
    assign scan       = scan_q;
    assign frame_done = fdone_q;

endmodule

`default_nettype wire

// File: doc/sev_scan_driver.md
SEV_SCAN_DRIVER -- requirements
Module: sev_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 100000, means clk cycles per digit slot (100 MHz -> 1 kHz digit rate, 250 Hz frame); legal range 2..2^20.
REQ-002 Port clk  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-003 Port clr  input  1  reset, synchronous, active-high.
REQ-004 Port value  input  16  four hex nibbles; value[3:0] is digit 0 (rightmost).
REQ-005 Port load  input  1  one-cycle strobe; captures value into the pending register.
REQ-006 Port lzb  input  1  leading-zero blanking enable, sampled every cycle.
REQ-007 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 Port scan  output  4  digit anodes, active-low, one-hot-low, registered.
REQ-009 Port frame_done  output  1  one-cycle pulse when the digit index wraps 3->0.

Function
REQ-010 Prescaler counts 0..SCAN_DIV-1 and wraps; tick asserts for the single cycle where count==SCAN_DIV-1.
REQ-011 Digit index idx (2 bits) advances 0->1->2->3->0 on each tick only.
REQ-012 Registered outputs: scan and seg reflect the idx and shadow contents of the previous cycle (1-cycle latency).
REQ-013 scan = 4'b1110, 1101, 1011, 0111 for idx 0..3, unless the digit is blanked (REQ-017).
REQ-014 seg hex encoding, active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-015 load=1 copies value into pending and sets pend_flag; a later load before commit overwrites pending (last write wins).
REQ-016 Commit: on a tick with idx==3 and pend_flag=1, shadow<=pending and pend_flag clears; the display changes only at frame boundaries (no tearing).
REQ-017 Blanking: when lzb=1, digit k (k=3,2,1) is blanked if shadow nibbles k..3 are all zero; digit 0 is never blanked; blanked digit drives scan=4'b1111 and seg=7'h7F.
REQ-018 Simultaneous load and commit in the same cycle: commit takes the old pending; the new value lands in pending with pend_flag remaining set, committed at the next frame boundary.
REQ-019 frame_done pulses on the same cycle as the commit tick (tick with idx==3), whether or not a commit occurs.
REQ-020 No load ever: shadow stays at its reset value, and the display keeps scanning it.

Reset
REQ-021 While clr=1 at a clock edge: prescaler=0, idx=0, pending=0, shadow=0, pend_flag=0, frame_done=0, scan=4'b1111, seg=7'h7F.
REQ-022 clr asserted mid-frame or mid-pending aborts everything; a pending value is lost, not committed.
REQ-023 First cycle after clr deasserts: scan=4'b1110, seg=7'h40 (digit 0 showing 0); idx advances after SCAN_DIV cycles.
REQ-024 load or lzb asserted together with clr is ignored.

Structure
REQ-025 The shared display package holds the hex-to-seg table, the SEG_BLANK (7'h7F) and SCAN_OFF (4'b1111) constants, and the digit-index type.
REQ-026 A single sub-module instance, sev_decoder (4-bit nibble in, 7-bit seg out), performs REQ-014; prescaler, index, buffering and blanking stay in this module.

Verification (SCAN_DIV=4)
REQ-027 Release clr, no load -> scan cycles 1110,1101,1011,0111 every 4 clocks with seg=40; frame_done every 16 clocks.
REQ-028 load value=16'h12AF mid-frame -> display unchanged until the cycle after frame_done, then digits 0..3 show 0E,08,24,79.
REQ-029 lzb=1, value=16'h0005 committed -> digits 3..1 scan=1111/seg=7F, digit 0 seg=12; value=0000 -> only digit 0 lit, seg=40.
REQ-030 load 16'h1111 then 16'h2222 in the same frame -> only 2222 is ever displayed (seg=24).
REQ-031 load 16'h3333 exactly on the idx==3 tick with 16'h1111 pending -> next frame shows 1111, the following frame shows 3333.
REQ-032 clr pulse mid-frame with a pending load -> outputs go to 1111/7F the next cycle, then restart at digit 0 showing 0; the pending value is never displayed.
